// File: rtl/piece_controller_if.sv
// Bundle between the piece controller and its neighbours: button/timing and
// board-status inputs in, piece coordinates and board-memory controls out.
interface piece_controller_if;
    localparam int unsigned XW = 5;
    localparam int unsigned YW = 6;
    localparam int unsigned RW = 10;
    localparam int unsigned TW = 3;
    localparam int unsigned LW = 8;

    logic          vs;
    logic          start;
    logic          left;
    logic          right;
    logic          rotate;
    logic          drop;
    logic          stopFalling;
    logic [RW-1:0] full_rows;

    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [XW-1:0] x2;
    logic [XW-1:0] x3;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [YW-1:0] y2;
    logic [YW-1:0] y3;
    logic          isStopped;
    logic          isLocking;
    logic          clearing;
    logic [RW-1:0] lineFill;
    logic [TW-1:0] piece_type;
    logic          game_over;
    logic [LW-1:0] lines;

    // Controller side
    modport master (
        input  vs, start, left, right, rotate, drop, stopFalling, full_rows,
        output x0, x1, x2, x3, y0, y1, y2, y3,
               isStopped, isLocking, clearing, lineFill, piece_type, game_over, lines
    );

    // Input logic / board-memory side
    modport slave (
        output vs, start, left, right, rotate, drop, stopFalling, full_rows,
        input  x0, x1, x2, x3, y0, y1, y2, y3,
               isStopped, isLocking, clearing, lineFill, piece_type, game_over, lines
    );
endinterface

// File: rtl/piece_controller.sv
// Active-tetromino sequencer: spawns pieces, applies gravity and player moves,
// and runs the lock / line-check / line-clear handshake with the board memory.
module piece_controller #(
    parameter int unsigned GRAVITY_FRAMES = 30
) (
    input  logic               clk,
    input  logic               reset,
    piece_controller_if.master bus
);
    localparam int unsigned XW = 5;
    localparam int unsigned YW = 6;
    localparam int unsigned OW = 3;
    localparam int unsigned FW = 6;
    localparam int unsigned NC = 4;
    localparam int unsigned RW = 10;
    localparam int unsigned TW = 3;
    localparam int unsigned LW = 8;
    localparam int unsigned CW = 4;

    localparam logic [TW-1:0] PIECE_O  = TW'(1);
    localparam logic [XW-1:0] SPAWN_X  = XW'(4);
    localparam logic [YW-1:0] SPAWN_Y  = YW'(18);
    localparam logic [YW-1:0] TOP_ROW  = YW'(18);
    localparam logic [FW-1:0] LAST_FRM = FW'(GRAVITY_FRAMES - 1);

    localparam logic [OW-1:0] N1 = 3'b111;
    localparam logic [OW-1:0] Z0 = 3'b000;
    localparam logic [OW-1:0] P1 = 3'b001;
    localparam logic [OW-1:0] P2 = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_FALL, S_LOCK, S_CHECK, S_CLEAR, S_GAMEOVER
    } state_e;

    typedef logic [NC-1:0][OW-1:0] offs_t;

    state_e state_q, state_d;

    logic [2:0]    lfsr_q, lfsr_d;
    logic [TW-1:0] type_q, type_d;
    logic [XW-1:0] ax_q, ax_d;
    logic [YW-1:0] ay_q, ay_d;
    offs_t         dx_q, dx_d, dy_q, dy_d;
    offs_t         rot_dx, rot_dy;
    logic [FW-1:0] frame_q, frame_d;
    logic [RW-1:0] rows_q, rows_d;
    logic [LW-1:0] lines_q, lines_d;

    logic [NC-1:0][XW-1:0] x_q, x_d;
    logic [NC-1:0][YW-1:0] y_q, y_d;
    logic is_stopped_q, is_stopped_d;
    logic is_locking_q, is_locking_d;
    logic clearing_q, clearing_d;
    logic game_over_q, game_over_d;

    logic vs_q, left_q, right_q, rotate_q;
    logic vs_rise, left_rise, right_rise, rotate_rise;
    logic tick, top_hit;

    // Signed cell coordinate = anchor + sign-extended offset
    function automatic logic signed [7:0] cell_pos(input logic [5:0] a, input logic [OW-1:0] d);
        logic signed [7:0] r;
        r = signed'({2'b00, a}) + signed'({{5{d[OW-1]}}, d});
        return r;
    endfunction

    function automatic logic fits(input logic [XW-1:0] ax, input logic [YW-1:0] ay,
                                  input offs_t dx, input offs_t dy);
        logic              ok;
        logic signed [7:0] cx;
        logic signed [7:0] cy;
        ok = 1'b1;
        for (int i = 0; i < NC; i++) begin
            cx = cell_pos({1'b0, ax}, dx[2'(i)]);
            cy = cell_pos(ay, dy[2'(i)]);
            if (cx < 8'sd0 || cx > 8'sd9 || cy < 8'sd0 || cy > 8'sd19) ok = 1'b0;
        end
        return ok;
    endfunction

    // Spawn offsets packed as {cell3, cell2, cell1, cell0}
    function automatic offs_t spawn_dx(input logic [TW-1:0] t);
        case (t)
            3'd1:    return {P1, Z0, Z0, P1};
            3'd2:    return {Z0, P1, Z0, N1};
            3'd3:    return {P1, Z0, Z0, N1};
            3'd4:    return {P1, Z0, Z0, N1};
            3'd5:    return {P1, P1, Z0, N1};
            3'd6:    return {N1, P1, Z0, N1};
            default: return {P2, P1, Z0, N1};
        endcase
    endfunction

    function automatic offs_t spawn_dy(input logic [TW-1:0] t);
        case (t)
            3'd1:    return {N1, N1, Z0, Z0};
            3'd2:    return {N1, Z0, Z0, Z0};
            3'd3:    return {Z0, N1, Z0, N1};
            3'd4:    return {N1, N1, Z0, Z0};
            3'd5:    return {N1, Z0, Z0, Z0};
            3'd6:    return {N1, Z0, Z0, Z0};
            default: return {Z0, Z0, Z0, Z0};
        endcase
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [RW-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < RW; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    assign vs_rise     = bus.vs & ~vs_q;
    assign left_rise   = bus.left & ~left_q;
    assign right_rise  = bus.right & ~right_q;
    assign rotate_rise = bus.rotate & ~rotate_q;
    assign tick        = (state_q == S_FALL) && vs_rise && (bus.drop || frame_q == LAST_FRM);
    assign top_hit     = (y_q[0] >= TOP_ROW) || (y_q[1] >= TOP_ROW) ||
                         (y_q[2] >= TOP_ROW) || (y_q[3] >= TOP_ROW);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.start) state_d = S_SPAWN;
            S_SPAWN:    state_d = S_FALL;
            S_FALL:     if (tick && bus.stopFalling) state_d = S_LOCK;
            S_LOCK:     state_d = top_hit ? S_GAMEOVER : S_CHECK;
            S_CHECK:    state_d = (|bus.full_rows) ? S_CLEAR : S_SPAWN;
            S_CLEAR:    state_d = S_SPAWN;
            S_GAMEOVER: state_d = S_GAMEOVER;
            default:    state_d = S_IDLE;
        endcase
    end

    // Piece, gravity and line-count datapath
    always_comb begin : datapath_next
        lfsr_d  = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
        type_d  = type_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        frame_d = frame_q;
        rows_d  = rows_q;
        lines_d = lines_q;
        for (int i = 0; i < NC; i++) begin
            rot_dx[2'(i)] = dy_q[2'(i)];
            rot_dy[2'(i)] = OW'(0) - dx_q[2'(i)];
        end
        case (state_q)
            S_SPAWN: begin
                type_d  = lfsr_q - 3'd1;
                ax_d    = SPAWN_X;
                ay_d    = SPAWN_Y;
                dx_d    = spawn_dx(type_d);
                dy_d    = spawn_dy(type_d);
                frame_d = '0;
            end
            S_FALL: begin
                if (vs_rise) frame_d = tick ? '0 : frame_q + FW'(1);
                // Requests coinciding with a gravity tick are dropped
                if (tick) begin
                    if (!bus.stopFalling) ay_d = ay_q - YW'(1);
                end else if (rotate_rise) begin
                    if (type_q != PIECE_O && fits(ax_q, ay_q, rot_dx, rot_dy)) begin
                        dx_d = rot_dx;
                        dy_d = rot_dy;
                    end
                end else if (left_rise) begin
                    if (fits(ax_q - XW'(1), ay_q, dx_q, dy_q)) ax_d = ax_q - XW'(1);
                end else if (right_rise) begin
                    if (fits(ax_q + XW'(1), ay_q, dx_q, dy_q)) ax_d = ax_q + XW'(1);
                end
            end
            S_CHECK: rows_d  = bus.full_rows;
            S_CLEAR: lines_d = lines_q + LW'(popcount(rows_q));
            default: ;
        endcase
    end

    // Output logic, registered below so every port comes from a flop
    always_comb begin : outputs_next
        is_stopped_d = (state_d != S_FALL);
        is_locking_d = (state_d == S_LOCK);
        clearing_d   = (state_d == S_CLEAR);
        game_over_d  = (state_d == S_GAMEOVER);
        for (int i = 0; i < NC; i++) begin
            x_d[2'(i)] = XW'(cell_pos({1'b0, ax_d}, dx_d[2'(i)]));
            y_d[2'(i)] = YW'(cell_pos(ay_d, dy_d[2'(i)]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q       <= 3'b001;
            type_q       <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            frame_q      <= '0;
            rows_q       <= '0;
            lines_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            is_stopped_q <= 1'b1;
            is_locking_q <= 1'b0;
            clearing_q   <= 1'b0;
            game_over_q  <= 1'b0;
            vs_q         <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            rotate_q     <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            type_q       <= type_d;
            ax_q         <= ax_d;
            ay_q         <= ay_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            frame_q      <= frame_d;
            rows_q       <= rows_d;
            lines_q      <= lines_d;
            x_q          <= x_d;
            y_q          <= y_d;
            is_stopped_q <= is_stopped_d;
            is_locking_q <= is_locking_d;
            clearing_q   <= clearing_d;
            game_over_q  <= game_over_d;
            vs_q         <= bus.vs;
            left_q       <= bus.left;
            right_q      <= bus.right;
            rotate_q     <= bus.rotate;
        end
    end

    assign bus.x0         = x_q[0];
    assign bus.x1         = x_q[1];
    assign bus.x2         = x_q[2];
    assign bus.x3         = x_q[3];
    assign bus.y0         = y_q[0];
    assign bus.y1         = y_q[1];
    assign bus.y2         = y_q[2];
    assign bus.y3         = y_q[3];
    assign bus.isStopped  = is_stopped_q;
    assign bus.isLocking  = is_locking_q;
    assign bus.clearing   = clearing_q;
    assign bus.lineFill   = '0;
    assign bus.piece_type = type_q;
    assign bus.game_over  = game_over_q;
    assign bus.lines      = lines_q;
endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: spawn, gravity, rotate/wall clamp,
// lock, line clear, game over and asynchronous reset.
module tb_piece_controller;
    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [2:0] m_lfsr;
    logic [2:0] exp_type;

    piece_controller_if bus ();

    piece_controller #(.GRAVITY_FRAMES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] lfsr_next(input logic [2:0] v);
        return {v[1:0], v[2] ^ v[1]};
    endfunction

    // Reference random source
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 3'b001;
        else       m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start so that SPAWN sees lfsr 001 (I piece); returns in FALL
    task automatic start_i();
        int n = 0;
        while (lfsr_next(m_lfsr) != 3'b001 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("lfsr_align", 32'(n < 10), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("spawn_stopped", 32'(bus.isStopped), 32'd1);
        @(negedge clk);
        chk("fall_running", 32'(bus.isStopped), 32'd0);
        chk("spawn_type_i", 32'(bus.piece_type), 32'd0);
    endtask

    task automatic vs_rise_one();
        @(negedge clk);
        bus.vs = 1'b1;
        @(negedge clk);
        bus.vs = 1'b0;
    endtask

    // which: 0 rotate, 1 left, 2 right
    task automatic press(input int which);
        @(negedge clk);
        if (which == 0)      bus.rotate = 1'b1;
        else if (which == 1) bus.left   = 1'b1;
        else                 bus.right  = 1'b1;
        @(negedge clk);
        bus.rotate = 1'b0;
        bus.left   = 1'b0;
        bus.right  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.vs = 1'b0; bus.start = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        bus.rotate = 1'b0; bus.drop = 1'b0; bus.stopFalling = 1'b0; bus.full_rows = '0;
        repeat (2) @(negedge clk);

        chk("rst_stopped",   32'(bus.isStopped),  32'd1);
        chk("rst_locking",   32'(bus.isLocking),  32'd0);
        chk("rst_clearing",  32'(bus.clearing),   32'd0);
        chk("rst_linefill",  32'(bus.lineFill),   32'd0);
        chk("rst_type",      32'(bus.piece_type), 32'd0);
        chk("rst_gameover",  32'(bus.game_over),  32'd0);
        chk("rst_lines",     32'(bus.lines),      32'd0);
        chk("rst_x0",        32'(bus.x0),         32'd0);
        chk("rst_y3",        32'(bus.y3),         32'd0);
        reset = 1'b0;

        // Spawn I at anchor (4,18)
        start_i();
        chk("spawn_x0", 32'(bus.x0), 32'd3);
        chk("spawn_x1", 32'(bus.x1), 32'd4);
        chk("spawn_x2", 32'(bus.x2), 32'd5);
        chk("spawn_x3", 32'(bus.x3), 32'd6);
        chk("spawn_y0", 32'(bus.y0), 32'd18);
        chk("spawn_y3", 32'(bus.y3), 32'd18);

        // Gravity every second frame, then every frame with drop
        vs_rise_one();
        chk("grav_f1_y0", 32'(bus.y0), 32'd18);
        vs_rise_one();
        chk("grav_f2_y0", 32'(bus.y0), 32'd17);
        vs_rise_one();
        vs_rise_one();
        chk("grav_f4_y0", 32'(bus.y0), 32'd16);
        chk("grav_f4_y3", 32'(bus.y3), 32'd16);
        chk("grav_x_hold", 32'(bus.x2), 32'd5);
        bus.drop = 1'b1;
        vs_rise_one();
        chk("drop1_y2", 32'(bus.y2), 32'd15);
        vs_rise_one();
        chk("drop2_y2", 32'(bus.y2), 32'd14);
        vs_rise_one();
        chk("drop3_y2", 32'(bus.y2), 32'd13);
        bus.drop = 1'b0;
        vs_rise_one();
        chk("nodrop_y2", 32'(bus.y2), 32'd13);

        // Rotate and wall clamp
        do_reset();
        start_i();
        press(0);
        chk("rot_x0", 32'(bus.x0), 32'd4);
        chk("rot_x3", 32'(bus.x3), 32'd4);
        chk("rot_y0", 32'(bus.y0), 32'd19);
        chk("rot_y1", 32'(bus.y1), 32'd18);
        chk("rot_y2", 32'(bus.y2), 32'd17);
        chk("rot_y3", 32'(bus.y3), 32'd16);
        @(negedge clk);
        bus.right = 1'b1;
        repeat (3) @(negedge clk);
        bus.right = 1'b0;
        chk("right_held_once", 32'(bus.x0), 32'd5);
        repeat (5) press(1);
        chk("left5_x0", 32'(bus.x0), 32'd0);
        repeat (2) press(1);
        chk("left_clamp_x0", 32'(bus.x0), 32'd0);
        chk("left_clamp_x3", 32'(bus.x3), 32'd0);
        press(0);
        chk("rot_wall_x2", 32'(bus.x2), 32'd0);
        chk("rot_wall_y0", 32'(bus.y0), 32'd19);

        // Lock without clear
        do_reset();
        start_i();
        vs_rise_one();
        vs_rise_one();
        chk("prelock_y1", 32'(bus.y1), 32'd17);
        bus.stopFalling = 1'b1;
        vs_rise_one();
        vs_rise_one();
        chk("lock_pulse", 32'(bus.isLocking), 32'd1);
        chk("lock_stopped", 32'(bus.isStopped), 32'd1);
        chk("lock_y1_held", 32'(bus.y1), 32'd17);
        @(negedge clk);
        chk("check_nolock", 32'(bus.isLocking), 32'd0);
        chk("check_noclear", 32'(bus.clearing), 32'd0);
        @(negedge clk);
        exp_type = m_lfsr - 3'd1;
        chk("respawn_stopped", 32'(bus.isStopped), 32'd1);
        @(negedge clk);
        chk("respawn_fall", 32'(bus.isStopped), 32'd0);
        chk("respawn_type", 32'(bus.piece_type), 32'(exp_type));
        chk("respawn_y1", 32'(bus.y1), 32'd18);
        chk("noclear_lines", 32'(bus.lines), 32'd0);

        // Lock with two full rows
        bus.stopFalling = 1'b0;
        vs_rise_one();
        vs_rise_one();
        chk("clr_prelock_y1", 32'(bus.y1), 32'd17);
        bus.stopFalling = 1'b1;
        bus.full_rows = 10'b0000000011;
        vs_rise_one();
        vs_rise_one();
        chk("clr_lock_pulse", 32'(bus.isLocking), 32'd1);
        @(negedge clk);
        chk("clr_check_noclear", 32'(bus.clearing), 32'd0);
        @(negedge clk);
        bus.full_rows = '0;
        chk("clr_pulse", 32'(bus.clearing), 32'd1);
        chk("clr_linefill", 32'(bus.lineFill), 32'd0);
        chk("clr_nolock", 32'(bus.isLocking), 32'd0);
        chk("clr_stopped", 32'(bus.isStopped), 32'd1);
        @(negedge clk);
        exp_type = m_lfsr - 3'd1;
        chk("clr_end", 32'(bus.clearing), 32'd0);
        chk("clr_lines", 32'(bus.lines), 32'd2);
        @(negedge clk);
        chk("clr_respawn_type", 32'(bus.piece_type), 32'(exp_type));
        chk("clr_respawn_fall", 32'(bus.isStopped), 32'd0);

        // Lock at the top: game over, start ignored, reset recovers
        vs_rise_one();
        vs_rise_one();
        chk("go_lock_pulse", 32'(bus.isLocking), 32'd1);
        @(negedge clk);
        chk("go_flag", 32'(bus.game_over), 32'd1);
        chk("go_stopped", 32'(bus.isStopped), 32'd1);
        chk("go_nolock", 32'(bus.isLocking), 32'd0);
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        chk("go_start_ignored", 32'(bus.game_over), 32'd1);
        chk("go_lines_kept", 32'(bus.lines), 32'd2);
        reset = 1'b1;
        #1;
        chk("async_rst_go", 32'(bus.game_over), 32'd0);
        chk("async_rst_lines", 32'(bus.lines), 32'd0);
        chk("async_rst_stopped", 32'(bus.isStopped), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.stopFalling = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", 32'(bus.isStopped), 32'd1);
        chk("idle_x0", 32'(bus.x0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/piece_controller.md
# piece_controller

Active-tetromino sequencer that drives the board memory's piece-coordinate and control inputs. It spawns pieces and applies gravity and player moves. It sequences the lock, line-check and line-clear handshake with the board memory. It sits between the input/timing logic (buttons, `vs`) and the board memory, and consumes the board's `stopFalling` and full-row flags.

## Interface
- `GRAVITY_FRAMES`, default 30: `vs` frames per gravity step while `drop` is low; range 1..63.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `vs`  in  1  vertical sync, synchronous to `clk`; each rising edge is one frame
- `start`  in  1  level; starts the game from IDLE
- `left`, `right`, `rotate`  in  1 each  button levels, already synchronized; rising edge = one request
- `drop`  in  1  level; while high, gravity steps every frame
- `stopFalling`  in  1  board memory: the piece cannot move down
- `full_rows`  in  10  board memory full-row flags, `{c9..c0}`
- `x0..x3`  out  5 each  piece cell columns, 0..9
- `y0..y3`  out  6 each  piece cell rows, 0..19, with 0 = bottom
- `isStopped`  out  1  piece is not falling
- `isLocking`  out  1  board memory writes the four cells this cycle
- `clearing`  out  1  board memory overwrites the latched full rows
- `lineFill`  out  10  row value written during clear; constant `10'b0`
- `piece_type`  out  3  current piece, 0..6 = I,O,T,S,Z,J,L
- `game_over`  out  1  game ended
- `lines`  out  8  cleared-line count, wraps mod 256

## Operation
- **Random source:** a 3-bit LFSR, seed `001`, advances every `clk`.
  - Next value: `{lfsr[1:0], lfsr[2]^lfsr[1]}`, period 7.
  - At SPAWN, `piece_type = lfsr - 1`.
- **Piece representation:** anchor `(ax, ay)` plus four signed 3-bit offsets.
  - Cell i = `(ax+dxi, ay+dyi)`.
  - Cell 1 is always `(0,0)`.
- **Spawn:** anchor `(4,18)`. Spawn offsets for cells 0..3:
  - I: `(-1,0)(0,0)(1,0)(2,0)`
  - O: `(1,0)(0,0)(0,-1)(1,-1)`
  - T: `(-1,0)(0,0)(1,0)(0,-1)`
  - S: `(-1,-1)(0,0)(0,-1)(1,0)`
  - Z: `(-1,0)(0,0)(0,-1)(1,-1)`
  - J: `(-1,0)(0,0)(1,0)(1,-1)`
  - L: `(-1,0)(0,0)(1,0)(-1,-1)`
- **Rotate (clockwise):** each offset `(dx,dy)` becomes `(dy,-dx)`. The O piece ignores rotate.
- **Move/rotate acceptance:** a move or rotate is accepted only if every resulting cell has x in 0..9 and y in 0..19. Otherwise it is discarded with no state change.
  - Lateral moves and rotation are checked against the walls only, not against board contents.
- **Gravity tick:**
  - The frame counter increments on each `vs` rising edge in FALL.
  - A tick occurs when the counter reaches `GRAVITY_FRAMES-1`, or on any frame while `drop=1`.
  - The counter clears on every tick and at SPAWN.
- **FSM:**
  - **IDLE:** `isStopped=1`. `start=1` → SPAWN.
  - **SPAWN (1 cycle):** load type, anchor and offsets → FALL.
  - **FALL:** `isStopped=0`.
    - On a tick with `stopFalling=1` → LOCK.
    - On a tick with `stopFalling=0`: `ay -= 1`.
    - With no tick, accept at most one request per cycle, priority rotate > left > right.
    - A request arriving on a tick cycle is dropped.
  - **LOCK (1 cycle):** `isLocking=1`, `isStopped=1`, coordinates held.
    - If any cell has y ≥ 18 → GAMEOVER, else → CHECK.
  - **CHECK (1 cycle):** `isStopped=1`, `isLocking=0`, `clearing=0`; the board latches its full rows this cycle.
    - Sample `full_rows`.
    - Nonzero → CLEAR; zero → SPAWN.
  - **CLEAR (1 cycle):** `clearing=1`, `isStopped=1`; `lines += popcount(sampled full_rows)` → SPAWN.
  - **GAMEOVER:** `game_over=1`, `isStopped=1`. Only `reset` exits this state; `start` is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - all `x`/`y` outputs 0
  - `isStopped=1`, `isLocking=0`, `clearing=0`
  - `lineFill=0`, `piece_type=0`, `game_over=0`, `lines=0`
  - LFSR `001`, frame counter 0
- An asynchronous reset mid-game returns to IDLE immediately; no lock or clear completes.
- Latencies:
  - `start` high → SPAWN next cycle → FALL the cycle after, with coordinates valid.
  - Accepted move → new coordinates one cycle after the button edge is sampled.
  - Gravity tick → `y` values decrement one cycle after the `vs` edge.
- `isLocking` and `clearing` are single-cycle pulses and never overlap.
- `isStopped` is high in every state except FALL.
- Button edges are detected against the previous-cycle value. A held button does not repeat.

## Test plan
- **Reset, then start:** reset, `start` pulse, LFSR forced to `001` → `piece_type=0` (I); cells x=3,4,5,6 at y=18; `isStopped=0` two cycles after `start`.
- **Gravity:** `GRAVITY_FRAMES=2`, 4 `vs` edges → all `y` values drop from 18 to 16. With `drop` held, 3 edges → y=15, 14, 13.
- **Rotate and wall clamp:** rotate the I at the spawn position → cells x=4, y=19,18,17,16. Then 5 `left` edges → x stops at 0 and the extra edges are discarded.
- **Lock without clear:** tie `stopFalling=1` at a tick → one-cycle `isLocking`, then CHECK with `full_rows=0` → SPAWN; `lines` unchanged.
- **Clear:** `full_rows=10'b0000000011` in CHECK → one-cycle `clearing` with `lineFill=0`; `lines` goes 0→2; then SPAWN.
- **Game over:** `stopFalling=1` on the first tick after spawn → LOCK → `game_over=1`. `start` is then ignored; `reset` returns to IDLE with `lines=0`.
